muldiv_seq: RTL

//   Iterative RV32M multiply/divide sequencer beside the single-cycle ALU, which has no M-extension ops.

---
 rtl/muldiv_seq.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide unit: one shared shift-add / restoring-divide datapath,
// 32 iterations plus a sign fix-up cycle; divide-by-zero and signed overflow bypass the loop.
module muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

    // state | meaning
    // IDLE  | waiting for start
    // CALC  | one radix-2 iteration per clock, counter tracks iterations
    // FIX   | sign correction and result select
    // DONE  | result valid, done pulse
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t             state_q;
    logic [2:0]         op_q;
    logic [CW-1:0]      cnt_q;
    logic [2*XLEN-1:0]  acc_q;
    logic [XLEN-1:0]    opnd_q;
    logic               neg_q;
    logic               neg_rem_q;
    logic               busy_q;
    logic               done_q;
    logic [XLEN-1:0]    result_q;

    logic               a_sgn, b_sgn, a_neg, b_neg;
    logic [XLEN-1:0]    a_mag, b_mag;
    logic               special;
    logic [XLEN-1:0]    spec_res_d;

    always_comb begin
        a_sgn = 1'b0;
        b_sgn = 1'b0;
        case (funct3)
            3'b000, 3'b001, 3'b100, 3'b110: begin
                a_sgn = 1'b1;
                b_sgn = 1'b1;
            end
            3'b010:  a_sgn = 1'b1;
            default: ;
        endcase
        a_neg = a_sgn & a[XLEN-1];
        b_neg = b_sgn & b[XLEN-1];
        // negating the most negative value yields the same bit pattern, read as unsigned
        a_mag = a_neg ? -a : a;
        b_mag = b_neg ? -b : b;
    end

    always_comb begin
        special    = 1'b0;
        spec_res_d = '0;
        if (funct3[2] && (b == '0)) begin
            special    = 1'b1;
            spec_res_d = funct3[1] ? a : '1;
        end else if (funct3[2] && !funct3[0] && (a == SMIN) && (b == '1)) begin
            special    = 1'b1;
            spec_res_d = funct3[1] ? '0 : SMIN;
        end
    end

    logic [XLEN:0]      mul_sum;
    logic [XLEN:0]      rem_sh;
    logic               rem_ge;
    logic [XLEN-1:0]    rem_sub;
    logic [2*XLEN-1:0]  acc_d;

    always_comb begin
        mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        rem_sh  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        rem_ge  = rem_sh >= {1'b0, opnd_q};
        rem_sub = rem_sh[XLEN-1:0] - opnd_q;
        if (op_q[2]) begin
            acc_d = {(rem_ge ? rem_sub : rem_sh[XLEN-1:0]), acc_q[XLEN-2:0], rem_ge};
        end else begin
            acc_d = {mul_sum, acc_q[XLEN-1:1]};
        end
    end

    logic [2*XLEN-1:0]  prod_fix;
    logic [XLEN-1:0]    rem_fix;
    logic [XLEN-1:0]    result_d;

    // the low half of the negated accumulator doubles as the negated quotient
    always_comb begin
        prod_fix = neg_q ? -acc_q : acc_q;
        rem_fix  = neg_rem_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        case (op_q)
            3'b000, 3'b100, 3'b101:  result_d = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011:  result_d = prod_fix[2*XLEN-1:XLEN];
            default:                 result_d = rem_fix;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
        end else if (flush) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        op_q      <= funct3;
                        cnt_q     <= '0;
                        neg_q     <= a_neg ^ b_neg;
                        neg_rem_q <= a_neg;
                        if (funct3[2]) begin
                            acc_q  <= {{XLEN{1'b0}}, a_mag};
                            opnd_q <= b_mag;
                        end else begin
                            acc_q  <= {{XLEN{1'b0}}, b_mag};
                            opnd_q <= a_mag;
                        end
                        if (special) begin
                            result_q <= spec_res_d;
                            done_q   <= 1'b1;
                            state_q  <= S_DONE;
                        end else begin
                            busy_q  <= 1'b1;
                            state_q <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(XLEN - 1)) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    result_q <= result_d;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                    state_q  <= S_DONE;
                end
                default: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
endmodule
